uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
- UART transmitter; the transmit-side counterpart of the RX sampling/deserializing path.
- Accepts a parallel byte on a single-cycle valid strobe and serializes it onto TX_OUT: start bit, data LSB-first, optional parity, stop.
- One bit is transmitted per CLK; CLK is the TX baud clock produced by the clock divider.
- Contains the frame FSM, serializer counter, parity calculator and output mux; all outputs registered.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (supported range 5..8).

Ports:
- CLK  input  1  TX baud clock; all logic on posedge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel data to transmit.
- DATA_VALID  input  1  P_DATA valid strobe; sampled on posedge CLK.
- PAR_EN  input  1  1 = insert parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- TX_OUT  output  1  serial line; idles high.
- Busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST low, async): state IDLE, TX_OUT=1, Busy=0, bit counter=0, data/config holding registers cleared.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept rule: DATA_VALID=1 at a posedge while state is IDLE or STOP.
  - On accept, latch P_DATA, PAR_EN and PAR_TYP into holding registers; next state is START.
  - Later changes on the inputs do not affect the frame in flight.
- DATA_VALID is ignored in START, DATA and PARITY; no queuing, no error flag.
- START: TX_OUT=0 for exactly 1 cycle; next state DATA, counter=0.
- DATA: TX_OUT=data[counter], LSB first, for DATA_WIDTH cycles.
  - Counter increments each cycle.
  - When counter reaches DATA_WIDTH-1: next state is PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = XOR of the latched data bits (even), or its inverse (odd); 1 cycle; next state STOP.
- STOP: TX_OUT=1 for 1 cycle.
  - If an accept occurs in this cycle, next state is START: back-to-back frames with no idle gap.
  - Otherwise next state is IDLE.
- Busy: registered. It is 1 in every cycle where state is not IDLE, i.e. from the cycle after the accept edge through the last stop cycle.
  - Busy drops to 0 only on return to IDLE.
  - It stays 1 across a back-to-back accept.
- Latency: the first start bit appears on TX_OUT one cycle after the accepting edge (TX_OUT and state change on the same edge).
- Frame length: 1 + DATA_WIDTH + PAR_EN + 1 cycles; 10 cycles for 8N1, 11 for 8E1/8O1.
- Reset mid-frame: immediate abort; TX_OUT=1 and Busy=0 asynchronously. After release, the block is idle and awaits a new accept.
- DATA_VALID held high continuously produces an accept at IDLE and at every STOP, giving continuous frames with the same or updated data.
- TX_OUT never glitches: it is driven from a single register.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 cycles, tracked by a one-bit stop counter.
  - The accept window is the second stop cycle only.
  - An accept in the first stop cycle is ignored.
  - Frame length grows by 1 (8N2 = 11 cycles).
- Undefined: single stop bit as described above; no stop counter logic synthesized.

Test Plan:
- Reset: hold RST=0 with random inputs -> TX_OUT=1, Busy=0. Pulse RST low mid-DATA -> TX_OUT=1 and Busy=0 immediately; next frame transmits cleanly.
- 8N1: P_DATA=0xA5, PAR_EN=0, 1-cycle DATA_VALID -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 starting the cycle after accept; Busy high 10 cycles.
- Parity: 0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1. 0x01 with PAR_TYP=1 -> parity bit 0; Busy high 11 cycles.
- Ignore while busy: strobe 0x3C with DATA_VALID again during DATA carrying 0xFF -> frame carries 0x3C only; line idles after the stop bit.
- Back-to-back: DATA_VALID held high, P_DATA=0x55 then 0x0F -> stop bit followed immediately by a start bit; Busy never deasserts; no idle cycle between frames.
- UART_TX_TWO_STOP_EN defined: 0xA5 8N2 -> two stop cycles of 1. Strobe in the first stop cycle is ignored; strobe in the second starts the next frame with no gap.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// Purpose : parallel-side and serial-side signal bundle of the UART frame transmitter.
// Ports   : P_DATA/DATA_VALID/PAR_EN/PAR_TYP flow toward the transmitter; TX_OUT/Busy flow back.
// Modports: master = byte source (also observes line + Busy), slave = uart_tx_frame.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// Purpose : UART frame serializer - start bit, DATA_WIDTH data bits LSB first, optional parity, stop.
// Latency : start bit appears on TX_OUT one CLK after the accepting edge; one bit per CLK.
// Backpr. : no queue; DATA_VALID is only honoured in IDLE or the final stop cycle, ignored otherwise.
//
// Ports   : CLK (TX baud clock, posedge), RST (async, active-low),
//           bus (uart_tx_frame_if.slave): P_DATA, DATA_VALID, PAR_EN, PAR_TYP in; TX_OUT, Busy out.
// Option  : define UART_TX_TWO_STOP_EN for two stop bits (accept window = second stop cycle only).
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_frame_if.slave bus
);
    localparam int            CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q,   state_d;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q,      tx_d;
    logic                  busy_q,    busy_d;

    // High during the stop cycle in which a new frame may be accepted.
    logic stop_last;

`ifdef UART_TX_TWO_STOP_EN
    logic stop_cnt_q, stop_cnt_d;
    assign stop_last = stop_cnt_q;
`else
    assign stop_last = 1'b1;
`endif

    logic accept;
    assign accept = bus.DATA_VALID &&
                    ((state_q == IDLE) || ((state_q == STOP) && stop_last));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop_cnt_d = stop_cnt_q;
`endif

        // Snapshot data and framing config so the frame in flight is immune to input changes.
        if (accept) begin
            data_d    = bus.P_DATA;
            par_en_d  = bus.PAR_EN;
            par_typ_d = bus.PAR_TYP;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                if (!stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                end else begin
                    stop_cnt_d = 1'b0;
                    state_d    = accept ? START : IDLE;
                end
`else
                state_d = accept ? START : IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is decoded from the next state so TX_OUT and state update on the same edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_q[cnt_d];
            PARITY:  tx_d = (^data_q) ^ par_typ_q;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_TX_TWO_STOP_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) stop_cnt_q <= 1'b0;
        else      stop_cnt_q <= stop_cnt_d;
    end
`endif

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;
endmodule
